// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte producers. A round-robin
// arbiter picks one pending requester, latches its byte, and walks the
// transmitter through exactly one frame using its enable/done handshake:
//   IDLE -> LAUNCH -> WAIT_START (tx_en high until tx_done drops)
//        -> WAIT_DONE (tx_en low until tx_done rises) -> IDLE
// Each wait phase is bounded by TIMEOUT cycles. On expiry the frame is
// abandoned and the sticky timeout_err flag is set.
//
// Build option:
//   UART_ARB_FIXED_PRIO_EN  when defined, the lowest pending index always
//                           wins and no round-robin pointer exists.
//                           Timing is identical in both builds.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   DATA_W   byte width, fixed at 8 to match the transmitter
//   TIMEOUT  max cycles in each wait phase before abort (>= 16)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    per-requester byte pending, held until req_ready
//   req_data     packed bytes, requester i at [i*8+7:i*8]
//   req_ready    one-hot, single-cycle accept pulse
//   tx_data      byte presented to the transmitter
//   tx_en        transmitter enable
//   tx_done      transmitter done level (low while a frame is in flight)
//   grant_id     index of the current or last granted requester
//   busy         high whenever the arbiter is not idle
//   timeout_err  sticky abort flag, cleared only by rst
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_en,
  input  logic                        tx_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // The counter holds the number of cycles already spent in a wait phase.
  // When it reaches TIMEOUT-1, the current cycle is the last one allowed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LAUNCH     = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;

  logic [NUM_REQ-1:0]  ready_nxt_s;
  logic [DATA_W-1:0]   tx_data_nxt_s;
  logic                tx_en_nxt_s;
  logic [ID_W-1:0]     grant_nxt_s;
  logic                busy_nxt_s;
  logic                err_nxt_s;

  logic                win_found_s;
  logic [ID_W-1:0]     win_idx_s;
  logic [ID_W-1:0]     idx_v_s;
  logic [DATA_W-1:0]   win_byte_s;
  logic [NUM_REQ-1:0]  win_onehot_s;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     rr_ptr_nxt_s;
`endif

`ifdef UART_ARB_FIXED_PRIO_EN
  // Fixed-priority winner select: the lowest pending index wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {ID_W{1'b0}};
    idx_v_s     = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v_s = ID_W'(k);
      if (!win_found_s && req_valid[idx_v_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end
`else
  // Round-robin winner select: search upward from the slot after the last
  // winner, wrapping modulo NUM_REQ, and take the first pending requester.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {ID_W{1'b0}};
    idx_v_s     = {ID_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v_s = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!win_found_s && req_valid[idx_v_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end
`endif

  // Byte mux and one-hot ready vector for the selected winner.
  always_comb begin
    win_byte_s   = {DATA_W{1'b0}};
    win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == win_idx_s) begin
        win_byte_s = req_data[k*DATA_W +: DATA_W];
      end else begin
        win_byte_s = win_byte_s;
      end
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    ready_nxt_s   = {NUM_REQ{1'b0}};   // req_ready is a single-cycle pulse
    tx_data_nxt_s = tx_data;           // held stable until the next grant
    tx_en_nxt_s   = tx_en;
    grant_nxt_s   = grant_id;
    busy_nxt_s    = busy;
    err_nxt_s     = timeout_err;
`ifndef UART_ARB_FIXED_PRIO_EN
    rr_ptr_nxt_s  = rr_ptr_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          tx_data_nxt_s = win_byte_s;
          grant_nxt_s   = win_idx_s;
          ready_nxt_s   = win_onehot_s;
          tx_en_nxt_s   = 1'b1;
          busy_nxt_s    = 1'b1;
          state_nxt_s   = ST_LAUNCH;
`ifndef UART_ARB_FIXED_PRIO_EN
          rr_ptr_nxt_s  = win_idx_s;
`endif
        end else begin
          tx_en_nxt_s = 1'b0;
          busy_nxt_s  = 1'b0;
        end
      end

      ST_LAUNCH: begin
        tx_en_nxt_s = 1'b1;
        cnt_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = ST_WAIT_START;
      end

      ST_WAIT_START: begin
        // Only an explicit 0 counts as "started"; an unknown level keeps
        // waiting, so a silent transmitter ends in a timeout.
        if (tx_done == 1'b0) begin
          tx_en_nxt_s = 1'b0;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_WAIT_DONE;
        end else if (cnt_r >= CNT_LAST) begin
          tx_en_nxt_s = 1'b0;
          err_nxt_s   = 1'b1;
          busy_nxt_s  = 1'b0;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        tx_en_nxt_s = 1'b0;
        if (tx_done == 1'b1) begin
          busy_nxt_s  = 1'b0;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else if (cnt_r >= CNT_LAST) begin
          err_nxt_s   = 1'b1;
          busy_nxt_s  = 1'b0;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end

      default: begin
        tx_en_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        cnt_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      req_ready   <= {NUM_REQ{1'b0}};
      tx_data     <= {DATA_W{1'b0}};
      tx_en       <= 1'b0;
      grant_id    <= {ID_W{1'b0}};
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr_r    <= ID_W'(NUM_REQ - 1);   // requester 0 wins first
`endif
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      req_ready   <= ready_nxt_s;
      tx_data     <= tx_data_nxt_s;
      tx_en       <= tx_en_nxt_s;
      grant_id    <= grant_nxt_s;
      busy        <= busy_nxt_s;
      timeout_err <= err_nxt_s;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr_r    <= rr_ptr_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed and randomized bench for uart_tx_arbiter. The bench is also the
// byte producers and the UART transmitter. The expected winner comes from a
// simple search over the pending-request vector and the last grant. Frame
// timing is derived from the handshake rules. Outputs are sampled and inputs
// are driven on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int          checks = 0;
  int          errors = 0;
  int          model_ptr;
  logic [7:0]  exp_byte;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected winner given the pending vector and the last granted index.
  function automatic int pick(input logic [3:0] v, input int ptr);
    int w;
    w = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) if (v[k]) w = k;
`else
    for (int k = NUM_REQ; k >= 1; k--) if (v[(ptr + k) % NUM_REQ]) w = (ptr + k) % NUM_REQ;
`endif
    return w;
  endfunction

  task automatic present(input int i);
    req_data[i*8 +: 8] = 8'($urandom);
    req_valid[i] = 1'b1;
  endtask

  // Called on the falling edge where the grant should be visible.
  task automatic check_grant(input bit refill, output int w);
    logic [3:0] oh;
    w = pick(req_valid, model_ptr);
    if (w < 0) w = 0;
    oh = 4'b0001 << w;
    exp_byte = req_data[w*8 +: 8];
    chk("grant_ready", 32'(req_ready), 32'(oh));
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("grant_data", 32'(tx_data), 32'(exp_byte));
    chk("grant_tx_en", 32'(tx_en), 32'd1);
    chk("grant_busy", 32'(busy), 32'd1);
    model_ptr = w;
    if (refill) present(w);
    else req_valid[w] = 1'b0;
  endtask

  // The transmitter starts s cycles after the grant and finishes l cycles later.
  task automatic frame(input int s, input int l, input logic [3:0] late);
    for (int i = 1; i <= s; i++) begin
      @(negedge clk);
      chk("start_tx_en", 32'(tx_en), 32'd1);
      chk("ready_pulse", 32'(req_ready), 32'd0);
      chk("data_hold", 32'(tx_data), 32'(exp_byte));
    end
    tx_done = 1'b0;
    for (int i = 1; i <= l; i++) begin
      @(negedge clk);
      chk("done_tx_en", 32'(tx_en), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      if (i == 1) begin
        for (int j = 0; j < NUM_REQ; j++) if (late[j] && !req_valid[j]) present(j);
      end
    end
    tx_done = 1'b1;
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_tx_en", 32'(tx_en), 32'd0);
    chk("end_no_grant", 32'(req_ready), 32'd0);
    chk("end_data_hold", 32'(tx_data), 32'(exp_byte));
  endtask

  task automatic grant_and_frame(input int s, input int l, input bit refill,
                                 input logic [3:0] late, output int w);
    @(negedge clk);
    check_grant(refill, w);
    frame(s, l, late);
  endtask

  initial begin
    int         w;
    logic [3:0] nv;

    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tx_done   = 1'b1;
    model_ptr = NUM_REQ - 1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    // Single request.
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    grant_and_frame(2, 12, 1'b0, 4'b0000, w);
    chk("single_id", 32'(w), 32'd0);
    chk("single_err", 32'(timeout_err), 32'd0);

    // Late arrival: req 2 shows up while req 0's frame is in WAIT_DONE.
    present(0);
    grant_and_frame(2, 6, 1'b0, 4'b0100, w);
    grant_and_frame(1, 3, 1'b0, 4'b0000, w);
    chk("late_id", 32'(w), 32'd2);

    // Start timeout: tx_done never drops.
    present(1);
    @(negedge clk);
    check_grant(1'b0, w);
    for (int i = 1; i <= TIMEOUT; i++) @(negedge clk);
    chk("sto_hold_en", 32'(tx_en), 32'd1);
    chk("sto_hold_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("sto_tx_en", 32'(tx_en), 32'd0);
    chk("sto_err", 32'(timeout_err), 32'd1);
    chk("sto_busy", 32'(busy), 32'd0);
    present(3);
    grant_and_frame(1, 4, 1'b0, 4'b0000, w);
    chk("sto_err_sticky", 32'(timeout_err), 32'd1);

    // Done timeout: tx_done drops and never rises.
    present(0);
    @(negedge clk);
    check_grant(1'b0, w);
    @(negedge clk);
    tx_done = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) @(negedge clk);
    chk("dto_hold_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("dto_busy", 32'(busy), 32'd0);
    chk("dto_err", 32'(timeout_err), 32'd1);
    tx_done = 1'b1;

    // Reset in the middle of WAIT_DONE.
    present(2);
    @(negedge clk);
    check_grant(1'b0, w);
    @(negedge clk);
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_tx_en", 32'(tx_en), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd0);
    chk("mrst_err", 32'(timeout_err), 32'd0);
    chk("mrst_grant", 32'(grant_id), 32'd0);
    chk("mrst_data", 32'(tx_data), 32'd0);
    model_ptr = NUM_REQ - 1;
    rst     = 1'b0;
    tx_done = 1'b1;
    present(0);
    present(3);
    grant_and_frame(2, 5, 1'b0, 4'b0000, w);
    chk("mrst_first", 32'(w), 32'd0);
    grant_and_frame(1, 5, 1'b0, 4'b0000, w);
    chk("mrst_second", 32'(w), 32'd3);

    // All four continuously valid.
    for (int j = 0; j < NUM_REQ; j++) present(j);
    for (int k = 0; k < 8; k++) begin
      grant_and_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 10)), 1'b1, 4'b0000, w);
`ifdef UART_ARB_FIXED_PRIO_EN
      chk("rr_order", 32'(w), 32'd0);
`else
      chk("rr_order", 32'(w), 32'(k % NUM_REQ));
`endif
    end

    // Wrap-around after grant 3: only requesters 1 and 3 pending.
    req_valid = 4'b1010;
    grant_and_frame(2, 4, 1'b0, 4'b0000, w);
    chk("wrap_first", 32'(w), 32'd1);
    grant_and_frame(2, 4, 1'b0, 4'b0000, w);
    chk("wrap_second", 32'(w), 32'd3);

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      nv = 4'($urandom);
      for (int j = 0; j < NUM_REQ; j++) if (nv[j] && !req_valid[j]) present(j);
      if (req_valid == 4'b0000) begin
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
      end else begin
        grant_and_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 10)),
                        1'($urandom), 4'($urandom), w);
      end
    end
    chk("final_err", 32'(timeout_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
